// File: rtl/rcpa_pkg.sv
// Shared definitions for the ripple-carry approximate adder: variant codes and
// 1-bit cell functions. Optional feature macro used elsewhere: RCPA_ERR_FLAG_EN.
package rcpa_pkg;

  localparam int unsigned RCPA_V1 = 1;
  localparam int unsigned RCPA_V2 = 2;
  localparam int unsigned RCPA_V3 = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Returns {cout, s}
  function automatic logic [1:0] fa_exact(input logic a, input logic b, input logic cin);
    return {maj3(a, b, cin), a ^ b ^ cin};
  endfunction

  // Returns {cout, s}; V3 bypasses the propagate logic entirely (cout=a, s=b)
  function automatic logic [1:0] fa_approx(input int unsigned variant,
                                           input logic a, input logic b, input logic cin);
    logic m;
    m = maj3(a, b, cin);
    case (variant)
      RCPA_V1: return {m, ~m};
      RCPA_V2: return {m, (a ^ b) | cin};
      default: return {a, b};
    endcase
  endfunction

endpackage

// File: rtl/n_bit_rcpa_fa_cell.sv
// One bit position of the adder: exact full adder, or the selected approximate cell.
module rcpa_fa_cell
  import rcpa_pkg::*;
#(
  parameter bit          APPROX  = 1'b0,
  parameter int unsigned VARIANT = RCPA_V1
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic [1:0] w_res;

  assign w_res     = APPROX ? fa_approx(VARIANT, a, b, cin) : fa_exact(a, b, cin);
  assign {cout, s} = w_res;

endmodule

// File: rtl/n_bit_rcpa.sv
// N-bit ripple-carry approximate adder with registered sum/fn/out_valid.
// Define RCPA_ERR_FLAG_EN to add the registered err port (mismatch vs exact sum).
module n_bit_rcpa
  import rcpa_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned K       = 4,
  parameter int unsigned VARIANT = RCPA_V1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  output logic [N-1:0] sum,
`ifdef RCPA_ERR_FLAG_EN
  output logic         err,
`endif
  output logic         fn
);

  if (VARIANT < RCPA_V1 || VARIANT > RCPA_V3) begin : g_bad_variant
    $error("n_bit_rcpa: VARIANT must be 1, 2 or 3");
  end
  if (N < 1 || K > N) begin : g_bad_width
    $error("n_bit_rcpa: require N >= 1 and K <= N");
  end

  logic [N:0]   w_c;
  logic [N-1:0] w_sum;
  logic         r_valid;
  logic [N-1:0] r_sum;
  logic         r_fn;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_chain
    rcpa_fa_cell #(
      .APPROX  (i < K),
      .VARIANT (VARIANT)
    ) u_cell (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (w_c[i]),
      .s    (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_fn    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sum <= w_sum;
        r_fn  <= w_c[N];
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign fn        = r_fn;

`ifdef RCPA_ERR_FLAG_EN
  logic [N:0] w_exact;
  logic       r_err;

  assign w_exact = {1'b0, A} + {1'b0, B};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (in_valid) begin
      r_err <= ({w_c[N], w_sum} != w_exact);
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_n_bit_rcpa.sv
// Scoreboard bench: six adders (V1..V3 at K=4 and at K=0) share one operand stream.
module tb_n_bit_rcpa;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] e1;
    logic [8:0] e2;
    logic [8:0] e3;
    bit         chk4;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic [7:0] A = 8'hFF;
  logic [7:0] B = 8'hFF;

  logic [7:0] s   [6];
  logic       f   [6];
  logic       ov  [6];
`ifdef RCPA_ERR_FLAG_EN
  logic       er  [6];
`endif

  exp_t       q[$];
  logic [8:0] last [6];
  logic       rst_edge = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 6; g++) begin : g_dut
    n_bit_rcpa #(
      .N       (8),
      .K       ((g < 3) ? 4 : 0),
      .VARIANT ((g % 3) + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (ov[g]),
      .sum       (s[g]),
`ifdef RCPA_ERR_FLAG_EN
      .err       (er[g]),
`endif
      .fn        (f[g])
    );
  end

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rst_edge <= rst;

  // Monitor: pops one expectation per presented result, checks hold when idle.
  always @(negedge clk) begin
    if (rst_edge) begin
      for (int g = 0; g < 6; g++) begin
        check($sformatf("reset ov g%0d", g), {8'h0, ov[g]}, 9'h000);
        check($sformatf("reset sum g%0d", g), {f[g], s[g]}, 9'h000);
`ifdef RCPA_ERR_FLAG_EN
        check($sformatf("reset err g%0d", g), {8'h0, er[g]}, 9'h000);
`endif
        last[g] = 9'h000;
      end
    end else if (ov[0]) begin
      if (q.size() == 0) begin
        check("unexpected out_valid", 9'h001, 9'h000);
      end else begin
        exp_t e;
        logic [8:0] ex;
        logic [8:0] want;
        e  = q.pop_front();
        ex = {1'b0, e.a} + {1'b0, e.b};
        for (int g = 0; g < 6; g++) begin
          check($sformatf("valid ov g%0d", g), {8'h0, ov[g]}, 9'h001);
          if (g < 3) want = (g == 0) ? e.e1 : (g == 1) ? e.e2 : e.e3;
          else       want = ex;
          if (g >= 3 || e.chk4) begin
            check($sformatf("sum g%0d a=%h b=%h", g, e.a, e.b), {f[g], s[g]}, want);
`ifdef RCPA_ERR_FLAG_EN
            check($sformatf("err g%0d a=%h b=%h", g, e.a, e.b), {8'h0, er[g]},
                  {8'h0, (want != ex)});
`endif
          end
          last[g] = {f[g], s[g]};
        end
      end
    end else begin
      for (int g = 0; g < 6; g++) begin
        check($sformatf("idle ov g%0d", g), {8'h0, ov[g]}, 9'h000);
        check($sformatf("hold sum g%0d", g), {f[g], s[g]}, last[g]);
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [8:0] e1,
                       input logic [8:0] e2, input logic [8:0] e3, input bit chk4);
    exp_t e;
    A = a;
    B = b;
    in_valid = 1'b1;
    e.a = a; e.b = b; e.e1 = e1; e.e2 = e2; e.e3 = e3; e.chk4 = chk4;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      A = ~A;
      B = B + 8'h35;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    // Back-to-back directed vectors
    drive(8'h32, 8'h01, 9'h03F, 9'h033, 9'h031, 1'b1);
    drive(8'h51, 8'h12, 9'h06F, 9'h063, 9'h062, 1'b1);
    drive(8'hFF, 8'hFF, 9'h1F0, 9'h1FE, 9'h1FF, 1'b1);
    idle(1);
    drive(8'h00, 8'h00, 9'h00F, 9'h000, 9'h000, 1'b1);
    idle(2);
    drive(8'h0F, 8'h01, 9'h010, 9'h01E, 9'h011, 1'b1);
    // Reset mid-stream with in_valid high: that sample must be dropped
    A = 8'hAA; B = 8'h55; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(8'h32, 8'h01, 9'h03F, 9'h033, 9'h031, 1'b1);
    idle(1);
    // Random operands: only the exact K=0 instances are checked here
    for (int i = 0; i < 1000; i++) begin
      drive(8'($urandom), 8'($urandom), 9'h000, 9'h000, 9'h000, 1'b0);
      if (i % 97 == 0) idle(1);
    end
    idle(4);
    check("scoreboard drained", 9'(q.size()), 9'h000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
